// File: rtl/s_mem_arbiter.sv
// S-memory arbiter: round-robin, non-preemptive ownership of a single-port
// S-memory shared by the init, shuffle and decrypt engines. Read-data valid
// pulses follow each issued read through a one-hot pipeline.
module s_mem_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [23:0] req_addr,
  input  logic [23:0] req_wrdata,
  input  logic [2:0]  req_wren,
  output logic [2:0]  gnt,
  output logic [1:0]  owner,
  output logic [2:0]  rd_valid,
  output logic [7:0]  rddata,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wrdata,
  output logic        mem_wren,
  input  logic [7:0]  mem_q
);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  rr_next;
  logic [2:0]  own_req;
  logic [2:0]  rd_issue;
  logic [READ_LATENCY:1][2:0] vld_pipe_q, vld_pipe_d;

  // First requester in round-robin order starting at ptr; lowest offset wins.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [2:0] g;
    logic [1:0] idx;
    g = '0;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (r[idx]) g = 3'b001 << idx;
    end
    return g;
  endfunction

  // Owner still holding its request this cycle (zero when idle or releasing).
  assign own_req  = gnt_q & req;
  // A read issues only while the owner holds req with write disabled.
  assign rd_issue = own_req & ~req_wren;

  // Pointer value that follows the current owner once it releases.
  always_comb begin
    rr_next = 2'd0;
    case (gnt_q)
      3'b001:  rr_next = 2'd1;
      3'b010:  rr_next = 2'd2;
      default: rr_next = 2'd0;
    endcase
  end

  // Grant FSM: grant from idle, hold while owner requests, hand over on release
  // in the same edge so no idle cycle appears between bursts.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = rr_pick(req, rr_ptr_q);
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (own_req == 3'b000) begin
          rr_ptr_d = rr_next;
          gnt_d    = rr_pick(req, rr_next);
          state_d  = (|gnt_d) ? GRANTED : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Read-valid shift pipeline: stage 1 captures the issue, last stage drives rd_valid.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    vld_pipe_d[1] = rd_issue;
    for (int k = 2; k <= READ_LATENCY; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
  end

  // State, grant, pointer and pipeline registers; reset aborts bursts and drops pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= 2'd0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Memory-side mux: only the owner's slices reach the memory, zero when idle.
  always_comb begin
    mem_addr   = '0;
    mem_wrdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_q[i]) begin
        mem_addr   |= req_addr[8*i +: 8];
        mem_wrdata |= req_wrdata[8*i +: 8];
      end
    end
  end

  // Write strobe is blocked while reset is high so a dying grant cannot write.
  assign mem_wren = (|(own_req & req_wren)) & ~reset;

  assign gnt      = gnt_q;
  assign owner    = {gnt_q[2] | gnt_q[1], gnt_q[2] | gnt_q[0]};
  assign rd_valid = vld_pipe_q[READ_LATENCY];
  assign rddata   = mem_q;

endmodule
